// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI SRAM slave: FSM encodings,
// response codes and the beat-size clamp.
package axi_slave_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_MAX    = 3'd2;

  // Byte step between beats; sizes wider than the 32-bit bus are clamped.
  function automatic logic [31:0] beat_incr(input logic [2:0] size);
    logic [2:0] s;
    s = (size > SIZE_MAX) ? SIZE_MAX : size;
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word-organised SRAM: one byte-enabled write port and one registered
// read port. A same-edge read of the written word returns the old data.
module axi_sram_mem
  import axi_slave_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] ram [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) ram[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= ram[raddr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI-style SRAM slave with independent incrementing write and read burst
// engines sharing one dual-port RAM.
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  wr_state_t   w_state, w_next;
  rd_state_t   r_state, r_next;
  logic        alive;
  logic [31:0] w_addr, r_addr, r_next_addr;
  logic [3:0]  w_len, w_cnt, r_len, r_cnt;
  logic [2:0]  w_size, r_size;
  logic        w_err;
  logic        aw_hs, w_hs, ar_hs, r_hs, w_final, r_final;
  logic        mem_re;
  logic [MEM_AW-1:0] mem_raddr;
  logic        unused_addr_bits;

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid & rready;
  assign w_final = (w_cnt == w_len);
  assign r_final = (r_cnt == r_len);
  assign rlast   = rvalid & r_final;
  assign rresp   = RESP_OKAY;
  assign r_next_addr = r_addr + beat_incr(r_size);
  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  // Keeps the address channels closed until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive <= 1'b0;
    else      alive <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = alive;
        if (awvalid && alive) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = alive;
        if (arvalid && alive) r_next = R_BURST;
      end
      R_BURST: begin
        rvalid = 1'b1;
        if (rready && r_final) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Burst length comes from awlen alone; wlast only feeds the error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_addr <= '0;
      w_len  <= '0;
      w_size <= '0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
      bid    <= '0;
      bresp  <= RESP_OKAY;
    end else if (aw_hs) begin
      bid    <= awid;
      w_addr <= {awaddr[31:2], 2'b00};
      w_len  <= awlen;
      w_size <= awsize;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr + beat_incr(w_size);
      w_cnt  <= w_cnt + 4'd1;
      if (wlast != w_final) w_err <= 1'b1;
      if (w_final) bresp <= (w_err || (wlast != w_final)) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
      r_cnt  <= '0;
      rid    <= '0;
    end else if (ar_hs) begin
      rid    <= arid;
      r_addr <= {araddr[31:2], 2'b00};
      r_len  <= arlen;
      r_size <= arsize;
      r_cnt  <= '0;
    end else if (r_hs && !r_final) begin
      r_addr <= r_next_addr;
      r_cnt  <= r_cnt + 4'd1;
    end
  end

  // The RAM fetches one beat ahead so rdata only moves when a beat is taken.
  assign mem_re    = ar_hs | (r_hs & ~r_final);
  assign mem_raddr = (r_state == R_IDLE) ? araddr[MEM_AW+1:2] : r_next_addr[MEM_AW+1:2];

  axi_sram_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_hs),
    .waddr (w_addr[MEM_AW+1:2]),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: drivers push expected beats and
// responses from a word-array model; a negedge monitor pops and compares.
module tb_axi_sram_slave;

  localparam int MEM_AW = 12;
  localparam int DEPTH  = 1 << MEM_AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [31:0] data; logic last; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

  rbeat_t      r_exp[$];
  bexp_t       b_exp[$];
  logic [31:0] model [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  // Word index of a beat: start rounded to a word, fixed byte step, aliased to the RAM depth.
  function automatic int word_of(input logic [31:0] start, input logic [2:0] size, input int beat);
    int unsigned step;
    logic [31:0] a;
    step = 1 << ((size > 3'd2) ? 2 : int'(size));
    a = (start & ~32'h3) + beat * step;
    return int'((a >> 2) & (DEPTH - 1));
  endfunction

  always @(negedge clk) begin
    rbeat_t re;
    bexp_t  be;
    if (rst && rvalid && rready) begin
      if (r_exp.size() == 0) failNow("unexpected_r_beat");
      else begin
        re = r_exp.pop_front();
        checkOutput("r_beat", {25'd0, rid, rresp, rlast, rdata}, {25'd0, re.id, 2'b00, re.last, re.data});
      end
    end
    if (rst && bvalid && bready) begin
      if (b_exp.size() == 0) failNow("unexpected_b");
      else begin
        be = b_exp.pop_front();
        checkOutput("b_resp", {58'd0, bid, bresp}, {58'd0, be.id, be.resp});
      end
    end
  end

  task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input int bad_beat, input bit gaps);
    int n, w;
    bit err, lst;
    bexp_t be;
    awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) begin failNow("aw_timeout"); awvalid = 1'b0; return; end
    @(posedge clk); #1 awvalid = 1'b0;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      lst = (i == int'(len)) ^ (i == bad_beat);
      if (lst != (i == int'(len))) err = 1'b1;
      w = word_of(addr, size, i);
      for (int b = 0; b < 4; b++) if (ws[i][b]) model[w][8*b +: 8] = wd[i][8*b +: 8];
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wdata = wd[i]; wstrb = ws[i]; wlast = lst; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 50);
      if (!wready) begin failNow("w_timeout"); wvalid = 1'b0; return; end
      @(posedge clk); #1 wvalid = 1'b0;
    end
    be.id = id; be.resp = err ? 2'b10 : 2'b00;
    b_exp.push_back(be);
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    if (!bvalid) failNow("b_timeout");
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input bit rnd, input int stall_beat,
                           input int stall_cycles, input bit check_lat);
    int n, got, stalled, cycles;
    rbeat_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id; e.data = model[word_of(addr, size, i)]; e.last = (i == int'(len));
      r_exp.push_back(e);
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) begin failNow("ar_timeout"); arvalid = 1'b0; r_exp.delete(); return; end
    @(posedge clk); #1 arvalid = 1'b0;
    got = 0; stalled = 0; cycles = 0;
    while (got <= int'(len) && cycles < 300) begin
      if (rnd) rready = ($urandom_range(0, 3) != 0);
      else if (got == stall_beat && stalled < stall_cycles) begin rready = 1'b0; stalled++; end
      else rready = 1'b1;
      @(negedge clk); cycles++;
      if (rvalid && rready) got++;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (got <= int'(len)) failNow("r_timeout");
    if (check_lat) checkOutput("r_stream_cycles", cycles, int'(len) + 1 + stall_cycles);
  endtask

  task automatic applyStimulus(input int iterations);
    logic [31:0] base;
    logic [3:0]  len;
    logic [2:0]  size;
    int bad;
    for (int k = 0; k < iterations; k++) begin
      len  = 4'($urandom_range(0, 15));
      size = 3'($urandom_range(0, 7));
      base = $urandom_range(0, 32'h3FF - 64) | ($urandom & 32'hFFFF_C000);
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      writeBurst(4'($urandom), base, len, size, bad, 1'b1);
      len  = 4'($urandom_range(0, 15));
      size = 3'($urandom_range(0, 7));
      base = $urandom_range(0, 32'h3FF - 64) | ($urandom & 32'hFFFF_C000);
      readBurst(4'($urandom), base, len, size, 1'b1, -1, 0, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, got;
    bit ar_pend, w_pend;
    rbeat_t e;
    bexp_t be;
    rst = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rresp, rdata},
                64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", {awready, arready}, 2'b11);

    // Known contents for the whole test window
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      writeBurst(4'(k), 32'(k * 64), 4'd15, 3'd2, -1, 1'b0);
    end

    // Four-beat write then read-back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h1111_1111 * (i + 1); ws[i] = 4'hF; end
    writeBurst(4'd1, 32'h100, 4'd3, 3'd2, -1, 1'b0);
    readBurst(4'd1, 32'h100, 4'd3, 3'd2, 1'b0, -1, 0, 1'b1);

    // Partial strobe merge
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'hF;
    writeBurst(4'd2, 32'h200, 4'd0, 3'd2, -1, 1'b0);
    wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
    writeBurst(4'd3, 32'h200, 4'd0, 3'd2, -1, 1'b0);
    readBurst(4'd3, 32'h200, 4'd0, 3'd2, 1'b0, -1, 0, 1'b1);
    checkOutput("strobe_merge_model", model[32'h200 >> 2], 32'hAA22_CC44);

    // Sixteen beats with a three-cycle stall at beat five
    readBurst(4'd4, 32'h000, 4'd15, 3'd2, 1'b0, 4, 3, 1'b1);

    // Early wlast, zero strobe beat, then read-back
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = (i == 2) ? 4'h0 : 4'hF; end
    writeBurst(4'd5, 32'h040, 4'd3, 3'd2, 1, 1'b0);
    writeBurst(4'd6, 32'h080, 4'd1, 3'd2, 1, 1'b0);
    readBurst(4'd5, 32'h040, 4'd3, 3'd2, 1'b0, -1, 0, 1'b0);

    // Reset during beat three of an eight-beat read
    for (int i = 0; i < 8; i++) begin
      e.id = 4'd9; e.data = model[word_of(32'h0C0, 3'd2, i)]; e.last = (i == 7);
      r_exp.push_back(e);
    end
    arid = 4'd9; araddr = 32'h0C0; arlen = 4'd7; arsize = 3'd2; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) failNow("ar_timeout_reset_case");
    @(posedge clk); #1 arvalid = 1'b0;
    rready = 1'b1; got = 0; n = 0;
    while (got < 2 && n < 50) begin
      @(negedge clk); n++;
      if (rvalid && rready) got++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    checkOutput("reset_mid_read", {rvalid, rlast, arready, awready, rid, rdata}, 64'd0);
    r_exp.delete();
    rready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_rerelease", {awready, arready}, 2'b11);
    readBurst(4'd10, 32'h0C0, 4'd7, 3'd2, 1'b0, -1, 0, 1'b1);

    // Concurrent write and read of the same word: read sees the old value
    wd[0] = 32'h0; ws[0] = 4'hF;
    writeBurst(4'd6, 32'h300, 4'd0, 3'd2, -1, 1'b0);
    awid = 4'd7; awaddr = 32'h300; awlen = 4'd0; awsize = 3'd2; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) failNow("aw_timeout_concurrent");
    @(posedge clk); #1 awvalid = 1'b0;
    e.id = 4'd8; e.data = model[word_of(32'h300, 3'd2, 0)]; e.last = 1'b1;
    r_exp.push_back(e);
    model[word_of(32'h300, 3'd2, 0)] = 32'hCAFE_F00D;
    be.id = 4'd7; be.resp = 2'b00;
    b_exp.push_back(be);
    arid = 4'd8; araddr = 32'h300; arlen = 4'd0; arsize = 3'd2; arvalid = 1'b1;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((arvalid || wvalid) && n < 50) begin
      @(negedge clk); n++;
      ar_pend = arvalid && arready;
      w_pend  = wvalid && wready;
      @(posedge clk); #1;
      if (ar_pend) arvalid = 1'b0;
      if (w_pend)  wvalid = 1'b0;
    end
    if (arvalid || wvalid) failNow("concurrent_handshake_timeout");
    arvalid = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1; n = 0;
    while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 50) begin
      @(negedge clk); n++;
      @(posedge clk); #1;
    end
    rready = 1'b0; bready = 1'b0;
    readBurst(4'd11, 32'h300, 4'd0, 3'd2, 1'b0, -1, 0, 1'b0);

    applyStimulus(25);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("r_queue_drained", r_exp.size(), 0);
    checkOutput("b_queue_drained", b_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
